// File: rtl/demux_1to2_sched.sv
// Valid/ready scheduler in front of a 1-to-2 demux: routes each input word to slot B or C
// by destination tag or round-robin, buffers one word per output and counts deliveries.

module demux_1to2 #(
  parameter int DATA_WIDTH = 2
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  Select,
  output logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] C
);

  // Steer A onto the selected output; the other output is held at zero.
  always_comb begin
    B = {DATA_WIDTH{1'b0}};
    C = {DATA_WIDTH{1'b0}};
    case (Select)
      1'b0:    B = A;
      1'b1:    C = A;
      default: begin
        B = {DATA_WIDTH{1'b0}};
        C = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

endmodule

module demux_1to2_sched #(
  parameter int DATA_WIDTH  = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_dest,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [DATA_WIDTH-1:0]  b_data,
  output logic                   c_valid,
  input  logic                   c_ready,
  output logic [DATA_WIDTH-1:0]  c_data,
  output logic                   rr_ptr,
  output logic [COUNT_WIDTH-1:0] cnt_b,
  output logic [COUNT_WIDTH-1:0] cnt_c
);

  logic                   tgt_s;
  logic                   free_b_s;
  logic                   free_c_s;
  logic                   accept_s;
  logic [DATA_WIDTH-1:0]  demux_b_s;
  logic [DATA_WIDTH-1:0]  demux_c_s;

  logic                   b_valid_r;
  logic                   c_valid_r;
  logic [DATA_WIDTH-1:0]  b_data_r;
  logic [DATA_WIDTH-1:0]  c_data_r;
  logic                   rr_ptr_r;
  logic [COUNT_WIDTH-1:0] cnt_b_r;
  logic [COUNT_WIDTH-1:0] cnt_c_r;

  demux_1to2 #(.DATA_WIDTH(DATA_WIDTH)) u_demux (
    .A      (in_data),
    .Select (tgt_s),
    .B      (demux_b_s),
    .C      (demux_c_s)
  );

  // Target choice and input handshake; in_ready deliberately ignores in_valid.
  always_comb begin
    tgt_s    = 1'b0;
    free_b_s = !b_valid_r || b_ready;
    free_c_s = !c_valid_r || c_ready;
    if (mode) begin
      tgt_s = rr_ptr_r;
    end else begin
      tgt_s = in_dest;
    end
    if (tgt_s) begin
      in_ready = free_c_s;
    end else begin
      in_ready = free_b_s;
    end
    accept_s = in_valid && in_ready;
  end

  // Output slots: a new word may land in the same cycle the old one drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid_r <= 1'b0;
      c_valid_r <= 1'b0;
      b_data_r  <= {DATA_WIDTH{1'b0}};
      c_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (accept_s && !tgt_s) begin
        b_valid_r <= 1'b1;
        b_data_r  <= demux_b_s;
      end else if (b_ready) begin
        b_valid_r <= 1'b0;
      end else begin
        b_valid_r <= b_valid_r;
      end
      if (accept_s && tgt_s) begin
        c_valid_r <= 1'b1;
        c_data_r  <= demux_c_s;
      end else if (c_ready) begin
        c_valid_r <= 1'b0;
      end else begin
        c_valid_r <= c_valid_r;
      end
    end
  end

  // Round-robin pointer advances only on accepts in round-robin mode; counters wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= 1'b0;
      cnt_b_r  <= {COUNT_WIDTH{1'b0}};
      cnt_c_r  <= {COUNT_WIDTH{1'b0}};
    end else begin
      if (accept_s && mode) begin
        rr_ptr_r <= ~rr_ptr_r;
      end
      if (b_valid_r && b_ready) begin
        cnt_b_r <= cnt_b_r + COUNT_WIDTH'(1);
      end
      if (c_valid_r && c_ready) begin
        cnt_c_r <= cnt_c_r + COUNT_WIDTH'(1);
      end
    end
  end

  assign b_valid = b_valid_r;
  assign c_valid = c_valid_r;
  assign b_data  = b_data_r;
  assign c_data  = c_data_r;
  assign rr_ptr  = rr_ptr_r;
  assign cnt_b   = cnt_b_r;
  assign cnt_c   = cnt_c_r;

endmodule

// File: tb/tb_demux_1to2_sched.sv
// Bench for demux_1to2_sched: slot-level reference model checked every falling edge,
// plus directed scenarios with hand-computed literal expectations.

module tb_demux_1to2_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_dest = 1'b0;
  logic       b_ready = 1'b0;
  logic       c_ready = 1'b0;
  logic [1:0] in_data = 2'b00;

  logic       in_ready, b_valid, c_valid, rr_ptr;
  logic [1:0] b_data, c_data;
  logic [7:0] cnt_b, cnt_c;
  logic       in_ready_w2, b_valid_w2, c_valid_w2, rr_ptr_w2;
  logic [1:0] b_data_w2, c_data_w2;
  logic [1:0] cnt_b_w2, cnt_c_w2;

  int compared = 0;
  int mismatched = 0;

  demux_1to2_sched dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .b_valid(b_valid), .b_ready(b_ready),
    .b_data(b_data), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .rr_ptr(rr_ptr), .cnt_b(cnt_b), .cnt_c(cnt_c)
  );

  demux_1to2_sched #(.COUNT_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_w2),
    .in_data(in_data), .in_dest(in_dest), .b_valid(b_valid_w2), .b_ready(b_ready),
    .b_data(b_data_w2), .c_valid(c_valid_w2), .c_ready(c_ready), .c_data(c_data_w2),
    .rr_ptr(rr_ptr_w2), .cnt_b(cnt_b_w2), .cnt_c(cnt_c_w2)
  );

  always #5 clk = ~clk;

  // Reference model: slot 0 = B, slot 1 = C; counters kept unbounded.
  logic       sv [2] = '{1'b0, 1'b0};
  logic [1:0] sd [2] = '{2'b00, 2'b00};
  int         cnt [2] = '{0, 0};
  logic       m_rr = 1'b0;

  function automatic int m_tgt();
    return mode ? int'(m_rr) : int'(in_dest);
  endfunction

  function automatic logic m_cons_ready(int x);
    return (x == 0) ? b_ready : c_ready;
  endfunction

  function automatic logic m_in_ready();
    int t;
    t = m_tgt();
    return !sv[t] || m_cons_ready(t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sv   <= '{1'b0, 1'b0};
      sd   <= '{2'b00, 2'b00};
      cnt  <= '{0, 0};
      m_rr <= 1'b0;
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (sv[x] && m_cons_ready(x)) cnt[x] <= cnt[x] + 1;
        if (in_valid && m_in_ready() && m_tgt() == x) begin
          sv[x] <= 1'b1;
          sd[x] <= in_data;
        end else if (m_cons_ready(x)) begin
          sv[x] <= 1'b0;
        end
      end
      if (in_valid && m_in_ready() && mode) m_rr <= !m_rr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_in_ready", 32'(in_ready), 32'(m_in_ready()));
    check("m_b_valid", 32'(b_valid), 32'(sv[0]));
    check("m_b_data", 32'(b_data), 32'(sd[0]));
    check("m_c_valid", 32'(c_valid), 32'(sv[1]));
    check("m_c_data", 32'(c_data), 32'(sd[1]));
    check("m_rr_ptr", 32'(rr_ptr), 32'(m_rr));
    check("m_cnt_b", 32'(cnt_b), 32'(cnt[0] % 256));
    check("m_cnt_c", 32'(cnt_c), 32'(cnt[1] % 256));
    check("m_cnt_b_w2", 32'(cnt_b_w2), 32'(cnt[0] % 4));
    check("m_cnt_c_w2", 32'(cnt_c_w2), 32'(cnt[1] % 4));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  int exp_w2 [5] = '{1, 2, 3, 0, 1};

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    #8 rst = 1'b0;
    step();

    // Destination tag to B
    mode = 1'b0; in_data = 2'b10; in_dest = 1'b0; in_valid = 1'b1; b_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_b_valid", 32'(b_valid), 32'd1);
    check("t1_b_data", 32'(b_data), 32'h2);
    check("t1_c_valid", 32'(c_valid), 32'd0);
    step();
    check("t1_cnt_b", 32'(cnt_b), 32'd1);
    check("t1_b_drained", 32'(b_valid), 32'd0);

    // Destination tag to C with a stalled consumer, no bypass
    in_dest = 1'b1; in_data = 2'b01; in_valid = 1'b1; c_ready = 1'b0;
    step();
    check("t2_c_valid", 32'(c_valid), 32'd1);
    check("t2_c_data", 32'(c_data), 32'h1);
    in_data = 2'b11;
    #1 check("t2_stall_ready", 32'(in_ready), 32'd0);
    step();
    check("t2_c_held", 32'(c_data), 32'h1);
    check("t2_no_bypass", 32'(b_valid), 32'd0);
    c_ready = 1'b1;
    #1 check("t2_ready_up", 32'(in_ready), 32'd1);
    step();
    check("t2_c_valid2", 32'(c_valid), 32'd1);
    check("t2_c_data2", 32'(c_data), 32'h3);
    check("t2_cnt_c", 32'(cnt_c), 32'd1);
    in_valid = 1'b0;
    step();
    check("t2_cnt_c2", 32'(cnt_c), 32'd2);

    // Round-robin, four words back to back
    mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 2'(i);
      step();
    end
    in_valid = 1'b0;
    check("t3_b_data", 32'(b_data), 32'h2);
    check("t3_c_data", 32'(c_data), 32'h3);
    check("t3_rr", 32'(rr_ptr), 32'd0);
    step();
    check("t3_cnt_b", 32'(cnt_b), 32'd3);
    check("t3_cnt_c", 32'(cnt_c), 32'd4);

    // Round-robin blocked by a full B slot
    b_ready = 1'b0; in_valid = 1'b1; in_data = 2'b01;
    step();
    in_data = 2'b10;
    step();
    in_data = 2'b11;
    #1 check("t4_blocked", 32'(in_ready), 32'd0);
    step();
    check("t4_rr_hold", 32'(rr_ptr), 32'd0);
    check("t4_b_held", 32'(b_data), 32'h1);
    b_ready = 1'b1;
    #1 check("t4_unblocked", 32'(in_ready), 32'd1);
    step();
    check("t4_b_new", 32'(b_data), 32'h3);
    check("t4_rr_adv", 32'(rr_ptr), 32'd1);
    check("t4_cnt_b", 32'(cnt_b), 32'd4);
    in_valid = 1'b0;
    step();
    check("t4_cnt_b2", 32'(cnt_b), 32'd5);

    // Asynchronous reset with both slots full
    b_ready = 1'b0; c_ready = 1'b0; in_valid = 1'b1; in_data = 2'b01;
    step();
    in_data = 2'b10;
    step();
    in_valid = 1'b0;
    check("t5_both_valid", 32'({b_valid, c_valid}), 32'h3);
    check("t5_cnt_b_pre", 32'(cnt_b), 32'd5);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_valids", 32'({b_valid, c_valid}), 32'h0);
    check("t5_rst_rr", 32'(rr_ptr), 32'd0);
    check("t5_rst_cnts", 32'({cnt_b, cnt_c}), 32'h0);
    check("t5_rst_data", 32'({b_data, c_data}), 32'h0);
    #1 rst = 1'b0;
    mode = 1'b1; in_valid = 1'b1; in_data = 2'b10; b_ready = 1'b1; c_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t5_first_b", 32'(b_valid), 32'd1);
    check("t5_first_b_data", 32'(b_data), 32'h2);
    check("t5_first_c", 32'(c_valid), 32'd0);
    step();

    // Narrow counter wrap
    pulse_reset();
    mode = 1'b0; in_dest = 1'b0; in_valid = 1'b1; b_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      in_data = 2'(i);
      step();
      check("t6_cnt_b_w2", 32'(cnt_b_w2), 32'(exp_w2[i]));
    end
    in_valid = 1'b0;
    step();

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      mode     = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_dest  = 1'($urandom_range(0, 1));
      in_data  = 2'($urandom_range(0, 3));
      b_ready  = ($urandom_range(0, 3) != 0);
      c_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    // Eight-bit counter wrap: 260 deliveries per output
    in_valid = 1'b0;
    pulse_reset();
    mode = 1'b1; b_ready = 1'b1; c_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 520; i++) begin
      in_data = 2'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t8_cnt_b_wrap", 32'(cnt_b), 32'd4);
    check("t8_cnt_c_wrap", 32'(cnt_c), 32'd4);
    check("t8_rr", 32'(rr_ptr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux_1to2_sched.md
Name: demux_1to2_sched

Overview:
- Scheduler and buffer in front of the parameterized demux_1to2 datapath (ports A, Select, B, C; parameter DATA_WIDTH).
- Accepts a valid/ready input stream and decides per word whether it goes to output B or output C.
- Drives the demux Select line and holds each output in a one-entry registered slot with its own valid/ready handshake.
- Keeps per-output delivery counters. Used wherever one producer feeds two consumers under a destination-tag or round-robin policy.

Parameters:
- DATA_WIDTH, 2, width of data words; passed through to the internal demux_1to2 instance.
- COUNT_WIDTH, 8, width of each per-output delivery counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  routing policy: 0 = destination tag, 1 = round-robin.
- in_valid  input  1  input word present.
- in_ready  output  1  scheduler accepts the input word this cycle.
- in_data  input  DATA_WIDTH  input word (drives demux A).
- in_dest  input  1  destination tag, used only when mode=0: 0 = B, 1 = C.
- b_valid  output  1  slot B holds a word.
- b_ready  input  1  consumer B takes the word.
- b_data  output  DATA_WIDTH  slot B contents.
- c_valid  output  1  slot C holds a word.
- c_ready  input  1  consumer C takes the word.
- c_data  output  DATA_WIDTH  slot C contents.
- rr_ptr  output  1  next round-robin target: 0 = B, 1 = C.
- cnt_b  output  COUNT_WIDTH  words delivered on B (b_valid && b_ready).
- cnt_c  output  COUNT_WIDTH  words delivered on C.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - b_valid, c_valid, rr_ptr, cnt_b, cnt_c all go to 0. b_data and c_data go to 0.
  - Any word in flight is dropped. in_ready follows the combinational rule below, so it is 1 after reset.
- Target selection, combinational:
  - tgt = in_dest when mode=0; tgt = rr_ptr when mode=1.
  - tgt drives Select of the internal demux_1to2 instance; in_data drives A.
  - Demux output B feeds slot B's D input; demux output C feeds slot C's D input.
- Slot free conditions:
  - free_B = !b_valid || b_ready.
  - free_C = !c_valid || c_ready.
- Input handshake:
  - in_ready = (tgt==0) ? free_B : free_C.
  - in_ready must not depend on in_valid.
  - Accept occurs when in_valid && in_ready.
- Slot update, per slot X:
  - Accept with tgt==X: X_data <= demux output, X_valid <= 1. This includes the cycle in which the old word drains, giving full throughput of one word per cycle per slot.
  - Otherwise, if X_ready: X_valid <= 0.
  - Otherwise the slot holds (X_data stable while X_valid && !X_ready).
- Latency: an accepted word appears on the slot outputs 1 cycle after the accept edge.
- Ordering:
  - Strict in-order acceptance. No bypass: if the target slot is full, in_ready=0 even when the other slot is free.
  - In mode 1, alternation is strict (B, C, B, C, ...). A stalled consumer blocks the stream.
- Round-robin pointer:
  - rr_ptr toggles on each accept while mode=1.
  - It holds when mode=0 or when no accept occurs.
  - A mode change takes effect on the next cycle's tgt. rr_ptr is not reset by a mode change.
- Counters:
  - cnt_b increments on b_valid && b_ready; cnt_c increments on c_valid && c_ready.
  - Both wrap modulo 2^COUNT_WIDTH (0xFF -> 0x00 at default).
  - A delivery on B and a delivery on C in the same cycle each increment their own counter.
- Simultaneous events:
  - Accept into B and drain of C in the same cycle are independent.
  - Accept into B with b_valid=1 and b_ready=1 overwrites with the new word; b_valid stays 1 and cnt_b increments.
- in_dest and in_data are don't-care when in_valid=0. No state changes without an accept or a drain.

Test Plan:
- Reset, then mode=0, in_data=2'b10, in_dest=0, in_valid=1 for 1 cycle, b_ready=1 -> next cycle b_valid=1, b_data=2'b10, c_valid=0; following cycle cnt_b=1.
- mode=0, in_dest=1, data 2'b01, c_ready=0 -> c_valid=1, c_data=2'b01 held. A second word with dest=1 sees in_ready=0. A word with dest=0 while the head word is dest=1 also sees in_ready=0 (no bypass). Raise c_ready -> second word accepted on the same edge that drains the first; c_valid stays 1 and cnt_c=1.
- mode=1, four words 0,1,2,3 (DATA_WIDTH=2), both readies high -> B receives 0,2 and C receives 1,3, one word per cycle. rr_ptr returns to 0; cnt_b=2, cnt_c=2.
- mode=1, b_ready=0 with slot B full and rr_ptr=0 -> in_ready=0 and rr_ptr holds. Release b_ready -> accept proceeds to B, rr_ptr becomes 1.
- Assert rst mid-stream with both slots valid and cnt_b=5 -> b_valid, c_valid, rr_ptr and counters go to 0 immediately (asynchronously, without a clock edge). The first word after release goes to B in mode 1.
- COUNT_WIDTH=2, 5 back-to-back deliveries on B -> cnt_b sequence 1,2,3,0,1.
